// File: rtl/stepdir_dispatch.sv
// stepdir_dispatch
//   Command sequencer between the host command decoder and NUM_CHANNELS
//   stepdir channels. Accepts one command at a time over a valid/ready
//   handshake and is the only writer of the per-channel move queues.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op              0=MOVE, 1=SET_CLOCK, 2=RESET_QUEUE, 3=DRAIN
//   cmd_channel         target channel for MOVE/RESET_QUEUE/DRAIN
//   cmd_data            move word, or channel mask in the low bits (SET_CLOCK)
//   cmd_clock           clock value for SET_CLOCK
//   ch_wr_data/wr_en    shared queue write data, one-hot write strobe
//   ch_full/ch_empty    per-channel queue status
//   ch_reset            per-channel queue reset pulse
//   do_reset_clock      per-channel clock-reset strobe, value on reset_clock
//   bad_channel         sticky flag: a command named a nonexistent channel
//   moves_written       wrapping count of move words written
//   busy                sequencer is not idle
module stepdir_dispatch #(
   parameter int NUM_CHANNELS = 6,
   parameter int CHANNEL_BITS = 3,
   parameter int MOVE_WIDTH   = 100,
   parameter int RESET_SETTLE = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [CHANNEL_BITS-1:0] cmd_channel,
   input  logic [MOVE_WIDTH-1:0]   cmd_data,
   input  logic [31:0]             cmd_clock,
   output logic [MOVE_WIDTH-1:0]   ch_wr_data,
   output logic [NUM_CHANNELS-1:0] ch_wr_en,
   input  logic [NUM_CHANNELS-1:0] ch_full,
   input  logic [NUM_CHANNELS-1:0] ch_empty,
   output logic [NUM_CHANNELS-1:0] ch_reset,
   output logic [NUM_CHANNELS-1:0] do_reset_clock,
   output logic [31:0]             reset_clock,
   output logic                    bad_channel,
   output logic [31:0]             moves_written,
   output logic                    busy
);

   localparam logic [1:0] OP_MOVE        = 2'd0;
   localparam logic [1:0] OP_SET_CLOCK   = 2'd1;
   localparam logic [1:0] OP_RESET_QUEUE = 2'd2;
   localparam logic [1:0] OP_DRAIN       = 2'd3;

   localparam int SETTLE_BITS = (RESET_SETTLE < 2) ? 1 : $clog2(RESET_SETTLE + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FULL,
      ST_WRITE_GAP,
      ST_RESET_WAIT,
      ST_DRAIN
   } state_t;

   state_t                  state_reg;
   logic [MOVE_WIDTH-1:0]   word_reg;
   logic [NUM_CHANNELS-1:0] sel_reg;
   logic [SETTLE_BITS-1:0]  settle_reg;

   // Channel index decoded to one-hot. An index past the last channel
   // decodes to all zeros, which doubles as the bad-channel test and keeps
   // every status lookup a simple AND-reduce with no out-of-range select.
   logic [NUM_CHANNELS-1:0] cmd_onehot;

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_decode
      assign cmd_onehot[gi] = (cmd_channel == CHANNEL_BITS'(gi));
   end

   logic cmd_hit;
   logic cmd_flagged;
   logic cmd_full;
   logic sel_full;
   logic sel_empty;

   assign cmd_hit     = |cmd_onehot;
   assign cmd_flagged = (cmd_op != OP_SET_CLOCK) && !cmd_hit;
   assign cmd_full    = |(cmd_onehot & ch_full);
   assign sel_full    = |(sel_reg & ch_full);
   assign sel_empty   = |(sel_reg & ch_empty);

   assign cmd_ready = (state_reg == ST_IDLE) && reset_n;
   assign busy      = (state_reg != ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         word_reg       <= '0;
         sel_reg        <= '0;
         settle_reg     <= '0;
         ch_wr_data     <= '0;
         ch_wr_en       <= '0;
         ch_reset       <= '0;
         do_reset_clock <= '0;
         reset_clock    <= '0;
         bad_channel    <= 1'b0;
         moves_written  <= '0;
      end else begin
         // Strobes are single-cycle; only one state arm raises any of them.
         ch_wr_en       <= '0;
         ch_reset       <= '0;
         do_reset_clock <= '0;

         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_flagged) begin
                     bad_channel <= 1'b1;
                  end else begin
                     case (cmd_op)
                        OP_MOVE: begin
                           word_reg <= cmd_data;
                           sel_reg  <= cmd_onehot;
                           if (cmd_full) begin
                              state_reg <= ST_WAIT_FULL;
                           end else begin
                              ch_wr_en      <= cmd_onehot;
                              ch_wr_data    <= cmd_data;
                              moves_written <= moves_written + 32'd1;
                              state_reg     <= ST_WRITE_GAP;
                           end
                        end
                        OP_SET_CLOCK: begin
                           do_reset_clock <= cmd_data[NUM_CHANNELS-1:0];
                           reset_clock    <= cmd_clock;
                        end
                        OP_RESET_QUEUE: begin
                           ch_reset   <= cmd_onehot;
                           settle_reg <= SETTLE_BITS'(RESET_SETTLE);
                           state_reg  <= ST_RESET_WAIT;
                        end
                        OP_DRAIN: begin
                           sel_reg   <= cmd_onehot;
                           state_reg <= ST_DRAIN;
                        end
                        default: ;
                     endcase
                  end
               end
            end

            ST_WAIT_FULL: begin
               if (!sel_full) begin
                  ch_wr_en      <= sel_reg;
                  ch_wr_data    <= word_reg;
                  moves_written <= moves_written + 32'd1;
                  state_reg     <= ST_WRITE_GAP;
               end
            end

            // One dead cycle so the queue's full flag catches up with the write.
            ST_WRITE_GAP: state_reg <= ST_IDLE;

            // The pulse cycle plus RESET_SETTLE further cycles are spent here.
            ST_RESET_WAIT: begin
               if (settle_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  settle_reg <= settle_reg - 1'b1;
               end
            end

            ST_DRAIN: begin
               if (sel_empty) begin
                  state_reg <= ST_IDLE;
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stepdir_dispatch.sv
// Testbench for stepdir_dispatch: directed steps from the test plan followed by
// a randomized command stream, each checked against timing and data rules
// derived from the command semantics.
module tb_stepdir_dispatch;

   localparam int NCH    = 6;
   localparam int CB     = 3;
   localparam int MW     = 100;
   localparam int SETTLE = 2;

   localparam logic [1:0] OP_MOVE        = 2'd0;
   localparam logic [1:0] OP_SET_CLOCK   = 2'd1;
   localparam logic [1:0] OP_RESET_QUEUE = 2'd2;
   localparam logic [1:0] OP_DRAIN       = 2'd3;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [1:0]     cmd_op;
   logic [CB-1:0]  cmd_channel;
   logic [MW-1:0]  cmd_data;
   logic [31:0]    cmd_clock;
   logic [MW-1:0]  ch_wr_data;
   logic [NCH-1:0] ch_wr_en;
   logic [NCH-1:0] ch_full;
   logic [NCH-1:0] ch_empty;
   logic [NCH-1:0] ch_reset;
   logic [NCH-1:0] do_reset_clock;
   logic [31:0]    reset_clock;
   logic           bad_channel;
   logic [31:0]    moves_written;
   logic           busy;

   int          checks     = 0;
   int          failures   = 0;
   int          wr_pulses  = 0;
   int          exp_pulses = 0;
   int          cyc        = 0;
   int          last_acc   = 0;
   logic [31:0] mw_exp     = 0;
   logic        bad_exp    = 0;
   logic [31:0] rc_exp     = 0;

   always #5 clk = ~clk;

   stepdir_dispatch #(
      .NUM_CHANNELS (NCH),
      .CHANNEL_BITS (CB),
      .MOVE_WIDTH   (MW),
      .RESET_SETTLE (SETTLE)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_channel    (cmd_channel),
      .cmd_data       (cmd_data),
      .cmd_clock      (cmd_clock),
      .ch_wr_data     (ch_wr_data),
      .ch_wr_en       (ch_wr_en),
      .ch_full        (ch_full),
      .ch_empty       (ch_empty),
      .ch_reset       (ch_reset),
      .do_reset_clock (do_reset_clock),
      .reset_clock    (reset_clock),
      .bad_channel    (bad_channel),
      .moves_written  (moves_written),
      .busy           (busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MW-1:0] rand_word();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[MW-1:0];
   endfunction

   always @(posedge clk) cyc++;

   // Per-cycle invariants: one strobe type at most, write strobe one-hot.
   always @(negedge clk) begin
      int kinds;
      if (reset_n === 1'b1) begin
         kinds = (|ch_wr_en) + (|ch_reset) + (|do_reset_clock);
         if (|ch_wr_en) wr_pulses++;
         check("one_strobe_type", kinds <= 1, 1);
         check("wr_en_onehot", $onehot0(ch_wr_en), 1);
      end
   end

   // Present a command (called just after a negedge), wait for acceptance,
   // return at the negedge following the accepting edge.
   task automatic send(input logic [1:0] op, input int ch, input logic [MW-1:0] data,
                       input logic [31:0] clkv);
      int n;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_channel = ch[CB-1:0];
      cmd_data    = data;
      cmd_clock   = clkv;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("accept_timeout", cmd_ready, 1);
      @(negedge clk);
      last_acc  = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic do_move(input int ch, input logic [MW-1:0] w, input int f);
      logic [NCH-1:0] oh;
      if (ch >= NCH) begin
         send(OP_MOVE, ch, w, $urandom());
         bad_exp = 1'b1;
         check("badmove_flag", bad_channel, 1);
         check("badmove_nowr", ch_wr_en, 0);
         check("badmove_ready", cmd_ready, 1);
         check("badmove_count", moves_written, mw_exp);
         return;
      end
      oh = NCH'(1) << ch;
      ch_full = NCH'($urandom());
      ch_full[ch] = (f > 0);
      send(OP_MOVE, ch, w, $urandom());
      check("move_no_clk_strobe", do_reset_clock, 0);
      for (int k = 1; k <= f; k++) begin
         check("move_wait_nowr", ch_wr_en, 0);
         check("move_wait_busy", busy, 1);
         check("move_wait_ready", cmd_ready, 0);
         if (k == f) ch_full[ch] = 1'b0;
         @(negedge clk);
      end
      mw_exp++;
      exp_pulses++;
      check("move_wr_en", ch_wr_en, oh);
      check("move_wr_data", ch_wr_data, w);
      check("move_count", moves_written, mw_exp);
      check("move_gap_ready", cmd_ready, 0);
      @(negedge clk);
      check("move_pulse_end", ch_wr_en, 0);
      check("move_back_idle", cmd_ready, 1);
   endtask

   task automatic do_setclk(input logic [NCH-1:0] mask, input logic [31:0] v, input int ch,
                            input bit hold);
      logic [MW-1:0] d;
      d = rand_word();
      d[NCH-1:0] = mask;
      send(OP_SET_CLOCK, ch, d, v);
      rc_exp = v;
      check("setclk_strobe", do_reset_clock, mask);
      check("setclk_value", reset_clock, v);
      check("setclk_ready", cmd_ready, 1);
      check("setclk_bad", bad_channel, bad_exp);
      if (hold) begin
         @(negedge clk);
         check("setclk_pulse_end", do_reset_clock, 0);
         check("setclk_hold", reset_clock, v);
      end
   endtask

   task automatic do_reset(input int ch);
      int n;
      send(OP_RESET_QUEUE, ch, rand_word(), $urandom());
      if (ch >= NCH) begin
         bad_exp = 1'b1;
         check("badreset_flag", bad_channel, 1);
         check("badreset_nopulse", ch_reset, 0);
         check("badreset_ready", cmd_ready, 1);
         return;
      end
      check("reset_pulse", ch_reset, NCH'(1) << ch);
      check("reset_nowr", ch_wr_en, 0);
      n = 0;
      while (cmd_ready === 1'b0 && n < 20) begin
         n++;
         @(negedge clk);
         if (cmd_ready === 1'b0) check("reset_pulse_end", ch_reset, 0);
      end
      check("reset_ready_low_cycles", n, 1 + SETTLE);
   endtask

   task automatic do_drain(input int ch, input int e);
      int n;
      ch_empty = NCH'($urandom());
      if (ch < NCH) ch_empty[ch] = (e == 0);
      send(OP_DRAIN, ch, rand_word(), $urandom());
      if (ch >= NCH) begin
         bad_exp = 1'b1;
         check("baddrain_flag", bad_channel, 1);
         check("baddrain_ready", cmd_ready, 1);
         return;
      end
      n = 0;
      while (cmd_ready === 1'b0 && n < 50) begin
         check("drain_busy", busy, 1);
         n++;
         if (n == e) ch_empty[ch] = 1'b1;
         @(negedge clk);
      end
      check("drain_cycles", n, (e == 0) ? 1 : e);
   endtask

   initial begin
      int prev;
      logic [MW-1:0] w;
      reset_n     = 1'b0;
      cmd_valid   = 1'b1;
      cmd_op      = OP_MOVE;
      cmd_channel = '0;
      cmd_data    = rand_word();
      cmd_clock   = '0;
      ch_full     = '0;
      ch_empty    = '1;

      // Reset held for 3 cycles with a command pending.
      repeat (3) begin
         @(negedge clk);
         check("rst_ready", cmd_ready, 0);
         check("rst_wr_en", ch_wr_en, 0);
         check("rst_ch_reset", ch_reset, 0);
         check("rst_clk_strobe", do_reset_clock, 0);
         check("rst_moves", moves_written, 0);
         check("rst_bad", bad_channel, 0);
         check("rst_busy", busy, 0);
         check("rst_reset_clock", reset_clock, 0);
      end
      reset_n   = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_wr_en", ch_wr_en, 0);

      // Burst of 4 moves to channel 2: accepts 2 cycles apart.
      for (int i = 0; i < 4; i++) begin
         prev = last_acc;
         do_move(2, rand_word(), 0);
         if (i > 0) check("burst_spacing", last_acc - prev, 2);
      end
      check("burst_count", moves_written, 4);

      // Backpressure: full for 10 cycles.
      prev = exp_pulses;
      do_move(1, rand_word(), 10);
      check("bp_single_pulse", wr_pulses - prev, 1);

      // SET_CLOCK then an immediate MOVE.
      do_setclk(6'b101011, 32'h12345678, 7, 1'b0);
      prev = last_acc;
      do_move(4, rand_word(), 0);
      check("setclk_then_move", last_acc - prev, 1);
      check("setclk_value_held", reset_clock, 32'h12345678);

      // RESET_QUEUE 3 then MOVE 3.
      do_reset(3);
      do_move(3, rand_word(), 0);

      // Invalid channel and drain.
      do_move(7, rand_word(), 0);
      do_drain(0, 5);

      // Reset mid-operation aborts a pending write.
      w = rand_word();
      ch_full = 6'b000010;
      send(OP_MOVE, 1, w, 0);
      check("abort_pending_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("abort_busy_cleared", busy, 0);
      check("abort_ready", cmd_ready, 0);
      check("abort_moves", moves_written, 0);
      check("abort_bad", bad_channel, 0);
      ch_full = '0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      mw_exp  = 0;
      bad_exp = 1'b0;
      rc_exp  = 0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_write", ch_wr_en, 0);
         check("abort_moves_zero", moves_written, 0);
         check("abort_idle", cmd_ready, 1);
      end

      // Randomized command stream.
      for (int i = 0; i < 60; i++) begin
         int op;
         int ch;
         op = int'($urandom_range(0, 3));
         ch = int'($urandom_range(0, 7));
         case (op)
            0: do_move(ch, rand_word(), int'($urandom_range(0, 3)));
            1: do_setclk(NCH'($urandom()), $urandom(), ch, 1'($urandom()));
            2: do_reset(ch);
            default: do_drain(ch, int'($urandom_range(0, 3)));
         endcase
         check("rand_moves", moves_written, mw_exp);
         check("rand_bad", bad_channel, bad_exp);
         check("rand_reset_clock", reset_clock, rc_exp);
      end

      @(negedge clk);
      #1;
      check("total_wr_pulses", wr_pulses, exp_pulses);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stepdir_dispatch.md
Name: stepdir_dispatch

Overview:
- Command sequencer between the host command decoder and NUM_CHANNELS stepdir instances.
- Takes one serialized command stream (valid/ready) and routes move words into per-channel move FIFOs, honouring queue_full backpressure.
- Issues synchronized clock-reset broadcasts across a channel mask, sequences per-channel queue resets including the stepdir post-reset settle time, and provides a drain barrier.
- Owns all writes into the stepdir queues; nothing else drives them.

Parameters:
NUM_CHANNELS, 6, number of stepdir channels served
CHANNEL_BITS, 3, width of channel index; must satisfy 2**CHANNEL_BITS >= NUM_CHANNELS
MOVE_WIDTH, 100, width of one move word (stepdir queue_wr_data width)
RESET_SETTLE, 2, idle cycles after a channel reset pulse before the next command is accepted

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=MOVE, 1=SET_CLOCK, 2=RESET_QUEUE, 3=DRAIN
cmd_channel  in  CHANNEL_BITS  target channel (MOVE/RESET_QUEUE/DRAIN)
cmd_data  in  MOVE_WIDTH  move word (MOVE); bits [NUM_CHANNELS-1:0] = channel mask (SET_CLOCK)
cmd_clock  in  32  clock value for SET_CLOCK
ch_wr_data  out  MOVE_WIDTH  shared write data to all channel queues
ch_wr_en  out  NUM_CHANNELS  one-hot queue write strobe
ch_full  in  NUM_CHANNELS  per-channel queue_full
ch_empty  in  NUM_CHANNELS  per-channel queue_empty
ch_reset  out  NUM_CHANNELS  per-channel reset pulse
do_reset_clock  out  NUM_CHANNELS  per-channel clock-reset strobe
reset_clock  out  32  clock value for do_reset_clock
bad_channel  out  1  sticky: command addressed channel >= NUM_CHANNELS
moves_written  out  32  count of move words written, wraps at 2**32
busy  out  1  state != IDLE

Behaviour:
- On reset_n low, asynchronously clear all outputs and state to 0 / IDLE: ch_wr_en, ch_reset, do_reset_clock, reset_clock, ch_wr_data, bad_channel, moves_written.
- All outputs are registered.
- cmd_ready = (state == IDLE) && reset_n.
- FSM states: IDLE, WAIT_FULL, WRITE_GAP, RESET_WAIT, DRAIN.
- IDLE, accept with invalid channel:
  - Applies to MOVE/RESET_QUEUE/DRAIN with cmd_channel >= NUM_CHANNELS.
  - Set bad_channel, drop the command, stay IDLE.
  - SET_CLOCK ignores cmd_channel and is never flagged.
- IDLE, accept MOVE to channel c:
  - Latch cmd_data and c.
  - If ch_full[c] = 0: next cycle ch_wr_en[c] = 1 for exactly one cycle, ch_wr_data = word, moves_written += 1. Go to WRITE_GAP.
  - If ch_full[c] = 1: go to WAIT_FULL.
- WAIT_FULL:
  - Hold the latched word.
  - In the first cycle ch_full[c] = 0, register the write as above and go to WRITE_GAP.
  - No timeout.
- WRITE_GAP:
  - One cycle with cmd_ready low, so the FIFO full flag reflects the write.
  - Returns to IDLE. Maximum MOVE throughput is one per 2 cycles.
- IDLE, accept SET_CLOCK:
  - Next cycle: do_reset_clock = cmd_data[NUM_CHANNELS-1:0] and reset_clock = cmd_clock, for one cycle, all masked channels in the same cycle.
  - Stay IDLE. Back-to-back SET_CLOCKs are allowed.
  - reset_clock holds its value afterwards.
  - An empty mask yields no strobe.
- IDLE, accept RESET_QUEUE c:
  - Next cycle ch_reset[c] = 1 for one cycle.
  - Then RESET_WAIT for RESET_SETTLE cycles with cmd_ready low, covering stepdir's delayed reset and empty-flag lag.
  - Then IDLE.
- IDLE, accept DRAIN c:
  - Enter DRAIN. Return to IDLE in the cycle after ch_empty[c] = 1 is sampled.
  - If ch_empty[c] is already 1 at acceptance, DRAIN lasts exactly one cycle.
- Simultaneous events:
  - At most one strobe type is active per cycle; the FSM guarantees this.
  - ch_wr_en is never asserted for a channel whose ch_reset is asserted in the same cycle.
- cmd_* are ignored whenever cmd_ready is low.
- reset_n asserted mid-operation aborts any pending write; the latched word is lost.

Test Plan:
- Reset: reset_n low for 3 cycles with cmd_valid = 1 → cmd_ready = 0; all strobes 0; moves_written = 0; after release cmd_ready = 1 in IDLE.
- Burst: 4 MOVEs to channel 2 with ch_full = 0 → ch_wr_en = 6'b000100 one cycle after each accept; accepts spaced 2 cycles apart; moves_written = 4; ch_wr_data matches each word.
- Backpressure: MOVE to channel 1 while ch_full[1] = 1 for 10 cycles → no write, busy = 1, cmd_ready = 0; write occurs 1 cycle after ch_full[1] drops; exactly one ch_wr_en pulse.
- SET_CLOCK: mask 6'b101011, cmd_clock = 0x12345678 → do_reset_clock = 6'b101011 for one cycle; reset_clock = 0x12345678; an immediately following MOVE is accepted the next cycle.
- RESET_QUEUE 3 then MOVE 3 → ch_reset[3] pulses for one cycle; cmd_ready stays low for 1 + RESET_SETTLE cycles; the subsequent write lands after the settle time.
- Invalid channel and DRAIN: MOVE to channel 7 → bad_channel = 1, no write, moves_written unchanged. DRAIN 0 with ch_empty[0] = 0 for 5 cycles → cmd_ready stays low until the cycle after ch_empty[0] rises.
